// File: rtl/ch_announce_tx.sv
// ch_announce_tx: transmit side of the cluster-head announcement exchange.
//
// Serializes 4-word announcements {CHANN_TYPE, CH ID, hop count, Q-value} onto a
// word-wide valid/ready channel. A CH originates with hops = 0; a member relays
// its chosen CH with hops = hopsFromCH + 1. After each message the block idles for
// ANNOUNCE_PERIOD cycles before looking at the enables again. HB_reset aborts any
// message and restarts announcing.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   en_CH          level, originate announcements as a CH (wins over en_relay)
//   en_relay       level, relay announcements for chosenCH as a member
//   HB_reset       reclustering pulse, highest priority
//   myNodeID       own node ID
//   myQValue       own Q-value
//   chosenCH       selected CH ID, all-ones = none
//   hopsFromCH     hops to chosen CH, all-ones = unknown
//   tx_ready       downstream accepts tx_data
//   tx_valid       tx_data is valid
//   tx_data        current message word
//   tx_busy        high while a message is being sent
//   announce_done  one-cycle pulse after the last word is accepted
module ch_announce_tx #(
  parameter int unsigned WORD_WIDTH      = 16,
  parameter int unsigned ANNOUNCE_PERIOD = 100,
  parameter int unsigned MAX_HOPS        = 15,
  parameter logic [WORD_WIDTH-1:0] CHANN_TYPE = 16'h0003
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_CH,
  input  logic                  en_relay,
  input  logic                  HB_reset,
  input  logic [WORD_WIDTH-1:0] myNodeID,
  input  logic [WORD_WIDTH-1:0] myQValue,
  input  logic [WORD_WIDTH-1:0] chosenCH,
  input  logic [WORD_WIDTH-1:0] hopsFromCH,
  input  logic                  tx_ready,
  output logic                  tx_valid,
  output logic [WORD_WIDTH-1:0] tx_data,
  output logic                  tx_busy,
  output logic                  announce_done
);

  localparam int unsigned CntW = (ANNOUNCE_PERIOD > 1) ? $clog2(ANNOUNCE_PERIOD) : 1;
  localparam logic [CntW-1:0]       CntLoad = CntW'(ANNOUNCE_PERIOD - 1);
  localparam logic [WORD_WIDTH-1:0] NoneId  = '1;
  localparam logic [WORD_WIDTH-1:0] MaxHops = WORD_WIDTH'(MAX_HOPS);

  typedef enum logic [1:0] {s_idle, s_send, s_wait, s_HBreset} state_e;

  state_e                state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0] snap_id_q, snap_id_d;
  logic [WORD_WIDTH-1:0] snap_hops_q, snap_hops_d;
  logic [WORD_WIDTH-1:0] snap_qv_q, snap_qv_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [WORD_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  done_q, done_d;

  logic                  relay_ok;
  logic [WORD_WIDTH-1:0] next_word;

  // The hop increment only happens under this guard, so it cannot wrap.
  assign relay_ok = en_relay && (chosenCH != NoneId) && (hopsFromCH < MaxHops);

  // Word that follows the one currently presented (index idx_q).
  always_comb begin
    case (idx_q)
      2'd0:    next_word = snap_id_q;
      2'd1:    next_word = snap_hops_q;
      2'd2:    next_word = snap_qv_q;
      default: next_word = CHANN_TYPE;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    snap_id_d   = snap_id_q;
    snap_hops_d = snap_hops_q;
    snap_qv_d   = snap_qv_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    done_d      = 1'b0;

    if (HB_reset) begin
      state_d    = s_HBreset;
      tx_valid_d = 1'b0;
      tx_data_d  = '0;
      idx_d      = '0;
      cnt_d      = '0;
    end else begin
      case (state_q)
        s_idle: begin
          if (en_CH || relay_ok) begin
            snap_id_d   = en_CH ? myNodeID : chosenCH;
            snap_hops_d = en_CH ? '0 : hopsFromCH + WORD_WIDTH'(1);
            snap_qv_d   = myQValue;
            state_d     = s_send;
            tx_valid_d  = 1'b1;
            tx_data_d   = CHANN_TYPE;
            idx_d       = '0;
          end
        end
        s_send: begin
          // tx_valid is always high here, so tx_ready alone marks a transfer.
          if (tx_ready) begin
            if (idx_q == 2'd3) begin
              state_d    = s_wait;
              tx_valid_d = 1'b0;
              tx_data_d  = '0;
              idx_d      = '0;
              cnt_d      = CntLoad;
              done_d     = 1'b1;
            end else begin
              idx_d     = idx_q + 2'd1;
              tx_data_d = next_word;
            end
          end
        end
        s_wait: begin
          if (cnt_q == '0) begin
            state_d = s_idle;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        s_HBreset: state_d = s_idle;
        default:   state_d = s_idle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= s_idle;
      idx_q       <= '0;
      cnt_q       <= '0;
      snap_id_q   <= '0;
      snap_hops_q <= '0;
      snap_qv_q   <= '0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      snap_id_q   <= snap_id_d;
      snap_hops_q <= snap_hops_d;
      snap_qv_q   <= snap_qv_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      done_q      <= done_d;
    end
  end

  assign tx_valid      = tx_valid_q;
  assign tx_data       = tx_data_q;
  assign tx_busy       = (state_q == s_send);
  assign announce_done = done_q;

endmodule

// File: tb/tb_ch_announce_tx.sv
module tb_ch_announce_tx;

  localparam int unsigned Period = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_CH = 1'b0;
  logic        en_relay = 1'b0;
  logic        HB_reset = 1'b0;
  logic [15:0] myNodeID = '0;
  logic [15:0] myQValue = '0;
  logic [15:0] chosenCH = 16'hffff;
  logic [15:0] hopsFromCH = 16'hffff;
  logic        tx_ready = 1'b0;
  logic        tx_valid;
  logic [15:0] tx_data;
  logic        tx_busy;
  logic        announce_done;

  always #5 clk = ~clk;

  ch_announce_tx #(
    .WORD_WIDTH     (16),
    .ANNOUNCE_PERIOD(Period),
    .MAX_HOPS       (15),
    .CHANN_TYPE     (16'h0003)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en_CH        (en_CH),
    .en_relay     (en_relay),
    .HB_reset     (HB_reset),
    .myNodeID     (myNodeID),
    .myQValue     (myQValue),
    .chosenCH     (chosenCH),
    .hopsFromCH   (hopsFromCH),
    .tx_ready     (tx_ready),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_busy      (tx_busy),
    .announce_done(announce_done)
  );

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [15:0] exp_q[$];
  int          exp_done = 0;
  int          done_seen = 0;
  int          msg_words = 0;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_data = '0;
  bit          rand_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: what message (if any) the node announces for the given inputs.
  function automatic bit model(input bit ench, input bit enrel, input logic [15:0] id,
                               input logic [15:0] q, input logic [15:0] ch,
                               input logic [15:0] hops, output logic [3:0][15:0] w);
    w = '0;
    if (ench) begin
      w[0] = 16'h0003; w[1] = id; w[2] = 16'h0000; w[3] = q;
      return 1'b1;
    end
    if (enrel && ch != 16'hffff && hops < 16'd15) begin
      w[0] = 16'h0003; w[1] = ch; w[2] = hops + 16'd1; w[3] = q;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic push_msg(input logic [3:0][15:0] w);
    for (int i = 0; i < 4; i++) exp_q.push_back(w[i]);
    exp_done++;
  endtask

  task automatic push4(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                       input logic [15:0] d);
    logic [3:0][15:0] w;
    w[0] = a; w[1] = b; w[2] = c; w[3] = d;
    push_msg(w);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!announce_done && n < 400) begin
      step();
      n++;
    end
    chk(name, announce_done, 1);
  endtask

  task automatic idle_gap();
    repeat (Period + 5) step();
  endtask

  task automatic quiet_window(input string name, input int cycles);
    int hits = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (tx_valid) hits++;
    end
    chk(name, hits, 0);
  endtask

  // Monitor: every accepted word is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (rst) begin
      msg_words  = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", tx_valid, 1);
        chk("hold_data", tx_data, prev_data);
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_word: got %0h expected none (t=%0t)", tx_data, $time);
        end else begin
          chk($sformatf("word%0d", msg_words), tx_data, exp_q.pop_front());
        end
        msg_words++;
      end
      if (announce_done) begin
        chk("done_words", msg_words, 4);
        msg_words = 0;
        done_seen++;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (HB_reset) begin
        msg_words  = 0;
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) tx_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [3:0][15:0] w;
    bit has;
    bit ench, enrel;
    logic [15:0] hsel[8];

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", tx_valid, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_busy", tx_busy, 0);
    chk("rst_done", announce_done, 0);
    rst = 1'b0;
    step();

    // Originate, always ready, and the repeat period
    myNodeID = 16'd5; myQValue = 16'd200; tx_ready = 1'b1;
    push4(16'h0003, 16'h0005, 16'h0000, 16'h00c8);
    push4(16'h0003, 16'h0005, 16'h0000, 16'h00c8);
    en_CH = 1'b1;
    chk("lat_before", tx_valid, 0);
    step();
    chk("lat_valid", tx_valid, 1);
    chk("lat_busy", tx_busy, 1);
    n = 0;
    while (!announce_done && n < 20) begin
      step();
      n++;
    end
    chk("b2b_cycles", n, 4);
    step();
    chk("done_one_cycle", announce_done, 0);
    chk("wait_not_busy", tx_busy, 0);
    n = 1;
    while (!tx_valid && n < 300) begin
      step();
      n++;
    end
    chk("period_gap", n, Period + 1);
    en_CH = 1'b0;
    wait_done("t1_second_done");
    idle_gap();

    // Relay with backpressure on word 2
    chosenCH = 16'd3; hopsFromCH = 16'd2; myQValue = 16'd50; en_relay = 1'b1;
    push4(16'h0003, 16'h0003, 16'h0003, 16'h0032);
    step();
    en_relay = 1'b0;
    step();
    step();
    chk("bp_word2", tx_data, 16'h0003);
    tx_ready = 1'b0;
    repeat (3) step();
    chk("bp_still_valid", tx_valid, 1);
    tx_ready = 1'b1;
    wait_done("bp_done");
    idle_gap();

    // Relay suppression
    en_relay = 1'b1; chosenCH = 16'hffff; hopsFromCH = 16'd2;
    quiet_window("sup_none_ch", 200);
    chosenCH = 16'd4; hopsFromCH = 16'd15;
    quiet_window("sup_max_hops", 200);
    hopsFromCH = 16'hffff;
    quiet_window("sup_unknown_hops", 200);
    en_relay = 1'b0;

    // Largest relayable hop count
    chosenCH = 16'd7; hopsFromCH = 16'd14; myQValue = 16'd9; en_relay = 1'b1;
    push4(16'h0003, 16'h0007, 16'h000f, 16'h0009);
    step();
    en_relay = 1'b0;
    wait_done("hops14_done");
    idle_gap();

    // Priority and snapshot
    myNodeID = 16'd5; myQValue = 16'd200; chosenCH = 16'd9; hopsFromCH = 16'd1;
    en_CH = 1'b1; en_relay = 1'b1;
    push4(16'h0003, 16'h0005, 16'h0000, 16'h00c8);
    step();
    en_CH = 1'b0; en_relay = 1'b0;
    step();
    myQValue = 16'd10;
    wait_done("snap_done");
    idle_gap();

    // HB_reset after word 1 accepted
    myNodeID = 16'h0021; myQValue = 16'h0044;
    exp_q.push_back(16'h0003);
    exp_q.push_back(16'h0021);
    push4(16'h0003, 16'h0021, 16'h0000, 16'h0044);
    en_CH = 1'b1;
    repeat (3) step();
    HB_reset = 1'b1; tx_ready = 1'b0;
    step();
    chk("hb_valid_drop", tx_valid, 0);
    chk("hb_no_done", announce_done, 0);
    HB_reset = 1'b0; tx_ready = 1'b1;
    step();
    chk("hb_gap", tx_valid, 0);
    step();
    chk("hb_restart_valid", tx_valid, 1);
    chk("hb_restart_word0", tx_data, 16'h0003);
    en_CH = 1'b0;
    wait_done("hb_done");
    idle_gap();

    // rst mid-message
    myNodeID = 16'h0055; myQValue = 16'h0066;
    exp_q.push_back(16'h0003);
    push4(16'h0003, 16'h0055, 16'h0000, 16'h0066);
    en_CH = 1'b1;
    step();
    step();
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", tx_valid, 0);
    chk("rst_mid_busy", tx_busy, 0);
    chk("rst_mid_done", announce_done, 0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_restart_valid", tx_valid, 1);
    chk("rst_restart_word0", tx_data, 16'h0003);
    en_CH = 1'b0;
    wait_done("rst_done");

    // Randomized messages with random backpressure and scrambled inputs
    hsel[0] = 16'd0;  hsel[1] = 16'd1;  hsel[2] = 16'd13; hsel[3] = 16'd14;
    hsel[4] = 16'd15; hsel[5] = 16'd16; hsel[6] = 16'hffff; hsel[7] = 16'd6;
    rand_ready = 1'b1;
    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 120)) step();
      ench  = ($urandom_range(0, 2) == 0);
      enrel = $urandom_range(0, 1) != 0;
      myNodeID   = 16'($urandom);
      myQValue   = 16'($urandom);
      chosenCH   = ($urandom_range(0, 4) == 0) ? 16'hffff : 16'($urandom_range(0, 300));
      hopsFromCH = hsel[$urandom_range(0, 7)];
      has = model(ench, enrel, myNodeID, myQValue, chosenCH, hopsFromCH, w);
      if (has) push_msg(w);
      en_CH = ench; en_relay = enrel;
      if (has) begin
        n = 0;
        while (!tx_valid && n < 300) begin
          step();
          n++;
        end
        chk("rnd_start", tx_valid, 1);
        en_CH = 1'b0; en_relay = 1'b0;
        n = 0;
        while (!announce_done && n < 300) begin
          myNodeID   = 16'($urandom);
          myQValue   = 16'($urandom);
          chosenCH   = 16'($urandom);
          hopsFromCH = 16'($urandom);
          step();
          n++;
        end
        chk("rnd_done", announce_done, 1);
      end else begin
        quiet_window("rnd_quiet", 150);
        en_CH = 1'b0; en_relay = 1'b0;
      end
    end
    rand_ready = 1'b0;
    tx_ready = 1'b1;
    repeat (10) step();

    chk("queue_empty", exp_q.size(), 0);
    chk("done_count", done_seen, exp_done);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
